fp_abs_max_reduce: RTL

- Streaming reduction stage directly downstream of the fp absolute-value stage.
- Consumes a packet of IEEE-754 single-precision magnitudes over a valid/ready stream, delimited by s_last.
- Returns the largest magnitude, its element index, the element count and NaN/overflow flags as one output beat.
- Used for vector norm-infinity and pivot search in the fp wrapper pipeline.

---
 rtl/fp_abs_max_reduce_pkg.sv | 31 +++
 rtl/fp_mag_cmp.sv | 28 ++
 rtl/fp_abs_max_reduce.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fp_abs_max_reduce_pkg.sv
// Shared fp32 helpers for the fp wrapper pipeline: field widths, canonical
// qNaN, magnitude masking, NaN detection and the abs-max reducer state type.
package fp_pkg;

  localparam int unsigned FP_W   = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 23;

  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC00000;

  typedef enum logic {
    ACCUM,
    OUTPUT
  } absmax_state_t;

  // Clear the sign bit so the value is its magnitude.
  function automatic logic [FP_W-1:0] fp_mag(input logic [FP_W-1:0] x);
    return {1'b0, x[FP_W-2:0]};
  endfunction

  // Exponent all ones with a non-zero mantissa.
  function automatic logic fp_is_nan(input logic [FP_W-1:0] x);
    return (x[FP_W-2 -: EXP_W] == '1) && (x[MANT_W-1:0] != '0);
  endfunction

  // Exponent field zero: +/-0 or a denormal.
  function automatic logic fp_is_sub(input logic [FP_W-1:0] x);
    return (x[FP_W-2 -: EXP_W] == '0);
  endfunction

endpackage

// File: rtl/fp_mag_cmp.sv
// Combinational compare of two fp32 magnitudes. Sign bits are ignored; the
// ordering is an unsigned compare of bits [30:0], which is exact for zeros,
// denormals, normals and +inf. NaN inputs are flagged, not ordered.
module fp_mag_cmp
  import fp_pkg::*;
(
  input  logic [FP_W-1:0] i_a,
  input  logic [FP_W-1:0] i_b,
  output logic            o_gt,
  output logic            o_eq,
  output logic            o_a_nan,
  output logic            o_b_nan
);

  logic [FP_W-1:0] w_a_mag;
  logic [FP_W-1:0] w_b_mag;

  // Magnitude ordering and NaN classification.
  always_comb begin
    w_a_mag = fp_mag(i_a);
    w_b_mag = fp_mag(i_b);
    o_gt    = (w_a_mag > w_b_mag);
    o_eq    = (w_a_mag == w_b_mag);
    o_a_nan = fp_is_nan(i_a);
    o_b_nan = fp_is_nan(i_b);
  end

endmodule

// File: rtl/fp_abs_max_reduce.sv
// Streaming abs-max reduction: folds a packet of fp32 magnitudes into one
// result beat (max, its index, count, NaN and overflow flags).
// Optional macro FP_ABS_MAX_REDUCE_SUBNORM_FLUSH_EN flushes exp==0 inputs to +0.
module fp_abs_max_reduce
  import fp_pkg::*;
#(
  parameter  int unsigned MAX_LEN = 1024,
  localparam int unsigned IDX_W   = $clog2(MAX_LEN)
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [FP_W-1:0]  s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [FP_W-1:0]  m_data,
  output logic [IDX_W-1:0] m_index,
  output logic [IDX_W:0]   m_count,
  output logic             m_nan,
  output logic             m_ovf
);

  localparam logic [IDX_W:0]   CNT_MAX  = (IDX_W+1)'(MAX_LEN);
  localparam logic [IDX_W:0]   CNT_LAST = (IDX_W+1)'(MAX_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_LEN - 1);

  absmax_state_t    r_state;
  logic             r_first;
  logic [FP_W-1:0]  r_max;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W:0]   r_count;
  logic             r_nan;
  logic             r_ovf;

  logic             r_s_ready;
  logic             r_m_valid;
  logic [FP_W-1:0]  r_m_data;
  logic [IDX_W-1:0] r_m_index;
  logic [IDX_W:0]   r_m_count;
  logic             r_m_nan;
  logic             r_m_ovf;

  logic [FP_W-1:0]  w_in;
  logic             w_accept;
  logic             w_gt;
  logic             w_eq;
  logic             w_in_nan;
  logic             w_max_nan;
  logic [IDX_W-1:0] w_beat_idx;
  logic [FP_W-1:0]  w_nxt_max;
  logic [IDX_W-1:0] w_nxt_idx;
  logic [IDX_W:0]   w_nxt_count;
  logic             w_nxt_nan;
  logic             w_nxt_ovf;

  // Input magnitude as seen by the comparator.
  always_comb begin
`ifdef FP_ABS_MAX_REDUCE_SUBNORM_FLUSH_EN
    w_in = fp_is_sub(s_data) ? '0 : fp_mag(s_data);
`else
    w_in = fp_mag(s_data);
`endif
  end

  fp_mag_cmp u_cmp (
    .i_a     (w_in),
    .i_b     (r_max),
    .o_gt    (w_gt),
    .o_eq    (w_eq),
    .o_a_nan (w_in_nan),
    .o_b_nan (w_max_nan)
  );

  assign w_accept = s_valid && r_s_ready;

  // Accumulator next state for the beat currently offered.
  // The beat index is derived from the running count, so it saturates at
  // MAX_LEN-1 in step with the count saturating at MAX_LEN.
  always_comb begin
    w_beat_idx  = (r_count >= CNT_LAST) ? IDX_LAST : r_count[IDX_W-1:0];
    w_nxt_max   = r_max;
    w_nxt_idx   = r_idx;
    w_nxt_nan   = r_nan;
    w_nxt_count = (r_count == CNT_MAX) ? r_count : r_count + 1'b1;
    w_nxt_ovf   = r_ovf || (r_count == CNT_MAX);
    if (r_first) begin
      w_nxt_max   = w_in;
      w_nxt_idx   = '0;
      w_nxt_nan   = w_in_nan;
      w_nxt_count = (IDX_W+1)'(1);
      w_nxt_ovf   = 1'b0;
    end else if (!r_nan && !w_max_nan) begin
      if (w_in_nan) begin
        w_nxt_nan = 1'b1;
        w_nxt_idx = w_beat_idx;
      end else if (w_gt && !w_eq) begin
        w_nxt_max = w_in;
        w_nxt_idx = w_beat_idx;
      end
    end
  end

  // Two-state FSM: accumulate beats, then hold the registered result.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state   <= ACCUM;
      r_first   <= 1'b1;
      r_max     <= '0;
      r_idx     <= '0;
      r_count   <= '0;
      r_nan     <= 1'b0;
      r_ovf     <= 1'b0;
      r_s_ready <= 1'b1;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_index <= '0;
      r_m_count <= '0;
      r_m_nan   <= 1'b0;
      r_m_ovf   <= 1'b0;
    end else if (r_state == ACCUM) begin
      if (w_accept) begin
        r_first <= 1'b0;
        r_max   <= w_nxt_max;
        r_idx   <= w_nxt_idx;
        r_count <= w_nxt_count;
        r_nan   <= w_nxt_nan;
        r_ovf   <= w_nxt_ovf;
        if (s_last) begin
          r_state   <= OUTPUT;
          r_s_ready <= 1'b0;
          r_m_valid <= 1'b1;
          r_m_data  <= w_nxt_nan ? FP_QNAN : w_nxt_max;
          r_m_index <= w_nxt_idx;
          r_m_count <= w_nxt_count;
          r_m_nan   <= w_nxt_nan;
          r_m_ovf   <= w_nxt_ovf;
        end
      end
    end else begin
      if (m_ready) begin
        r_state   <= ACCUM;
        r_first   <= 1'b1;
        r_max     <= '0;
        r_idx     <= '0;
        r_count   <= '0;
        r_nan     <= 1'b0;
        r_ovf     <= 1'b0;
        r_s_ready <= 1'b1;
        r_m_valid <= 1'b0;
        r_m_data  <= '0;
        r_m_index <= '0;
        r_m_count <= '0;
        r_m_nan   <= 1'b0;
        r_m_ovf   <= 1'b0;
      end
    end
  end

  assign s_ready = r_s_ready;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_index = r_m_index;
  assign m_count = r_m_count;
  assign m_nan   = r_m_nan;
  assign m_ovf   = r_m_ovf;

endmodule
